im_arbiter: RTL and testbench

IM_ARBITER -- requirements
Module: im_arbiter

---
 rtl/im_arbiter_pkg.sv | 30 +++
 rtl/im_grant.sv | 46 ++++
 rtl/im_arbiter.sv | 107 ++++++++++
 tb/tb_im_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_arbiter_pkg.sv
// Shared cpu package: instruction-memory map defaults, arbiter port select, address check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package im_arbiter_pkg;

  // Byte address of instruction-memory word 0 and memory size in 32-bit words.
  localparam logic [31:0] BASE_ADDR  = 32'h0000_3000;
  localparam int unsigned DEPTH      = 1024;

  // Loader may be denied at most this many consecutive cycles.
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned CNT_W      = 3;

  // Which requester owns an in-flight response.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_e;

  // True when a byte address is outside the memory window or not word aligned.
  // The upper bound is computed in 34 bits so a window ending at 4 GiB cannot wrap.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [33:0] w_lim;
    w_lim = {2'b00, base} + (34'(depth) << 2);
    return (addr < base) || ({2'b00, addr} >= w_lim) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/im_grant.sv
// Fixed-priority grant (fetch first) with a loader starvation counter.
// Latency: grants are combinational, same cycle as the request; counter updates on clk.
// Backpressure: a denied requester simply keeps its request high; the loader wins once starved.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   if_req, ld_req      fetch / loader requests
//   if_gnt, ld_gnt      one-hot-or-zero grants, forced low while in reset
module im_grant #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_req,
  input  logic ld_req,
  output logic if_gnt,
  output logic ld_gnt
);

  import im_arbiter_pkg::*;

  logic [CNT_W-1:0] r_cnt;
  logic             w_starved;

  assign w_starved = (r_cnt == CNT_W'(STARVE_MAX));

  // Loader wins when fetch is idle or when it has waited STARVE_MAX cycles.
  // Gating with reset_n keeps the grants (and everything derived from them) low
  // while reset is asserted, independent of the request inputs.
  assign ld_gnt = reset_n & ld_req & (~if_req | w_starved);
  assign if_gnt = reset_n & if_req & ~(ld_req & w_starved);

  // Count consecutive denied loader cycles; saturate rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (ld_req && !ld_gnt) begin
      if (!w_starved) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/im_arbiter.sv
// Two-port (fetch / loader) arbiter in front of a single-port synchronous instruction memory.
// Latency: grant same cycle; read response (rvalid/rdata/err) exactly one cycle after grant.
// Backpressure: none on responses; requests are held off only by withholding the grant.
//
// Ports:
//   clk, reset_n                              clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt                  fetch read request and grant
//   if_rvalid/if_rdata/if_err                 fetch read response
//   ld_req/ld_we/ld_addr/ld_wdata -> ld_gnt   loader read/write request and grant
//   ld_rvalid/ld_rdata/ld_err                 loader read response
//   im_en/im_we/im_addr/im_wdata, im_rdata    memory side; im_rdata valid one cycle after a read
module im_arbiter #(
  parameter logic [31:0] BASE_ADDR  = im_arbiter_pkg::BASE_ADDR,
  parameter int unsigned DEPTH      = im_arbiter_pkg::DEPTH,
  parameter int unsigned STARVE_MAX = im_arbiter_pkg::STARVE_MAX,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  // fetch port
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  // loader / debug port
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  output logic          ld_err,
  // memory
  output logic          im_en,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  input  logic [31:0]   im_rdata
);

  import im_arbiter_pkg::*;

  logic        w_any_gnt;
  logic [31:0] w_addr;
  logic [31:0] w_off;
  logic        w_bad;
  logic        w_is_wr;
  logic        w_is_rd;
  port_e       w_port;

  logic        r_resp_valid;
  logic        r_resp_err;
  port_e       r_resp_port;

  im_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk     (clk),
    .reset_n (reset_n),
    .if_req  (if_req),
    .ld_req  (ld_req),
    .if_gnt  (if_gnt),
    .ld_gnt  (ld_gnt)
  );

  // Grants are mutually exclusive, so the winner's request is selected by ld_gnt alone.
  assign w_any_gnt = if_gnt | ld_gnt;
  assign w_port    = ld_gnt ? PORT_LD : PORT_IF;
  assign w_addr    = ld_gnt ? ld_addr : if_addr;
  assign w_off     = w_addr - BASE_ADDR;
  assign w_bad     = addr_bad(w_addr, BASE_ADDR, DEPTH);
  assign w_is_wr   = ld_gnt & ld_we;
  assign w_is_rd   = w_any_gnt & ~w_is_wr;

  // Bad requests are still granted but never touch the memory. The memory-side
  // buses are zeroed when unused so they read 0 in reset and when idle.
  assign im_en     = w_any_gnt & ~w_bad;
  assign im_we     = im_en & w_is_wr;
  assign im_addr   = im_en ? w_off[AW+1:2] : '0;
  assign im_wdata  = im_we ? ld_wdata : '0;

  // One-deep response tracker: a read granted this cycle answers next cycle on
  // its own port, so back-to-back grants give one response per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_port  <= PORT_IF;
    end else begin
      r_resp_valid <= w_is_rd;
      r_resp_err   <= w_is_rd & w_bad;
      r_resp_port  <= w_port;
    end
  end

  // Data is passed only for a good response; otherwise the data bus reads 0.
  assign if_rvalid = r_resp_valid & (r_resp_port == PORT_IF);
  assign ld_rvalid = r_resp_valid & (r_resp_port == PORT_LD);
  assign if_err    = if_rvalid & r_resp_err;
  assign ld_err    = ld_rvalid & r_resp_err;
  assign if_rdata  = (if_rvalid & ~r_resp_err) ? im_rdata : 32'h0;
  assign ld_rdata  = (ld_rvalid & ~r_resp_err) ? im_rdata : 32'h0;

endmodule

// File: tb/tb_im_arbiter.sv
// Randomized plus directed bench for im_arbiter with a scoreboard and a byte-addressed reference memory.
// Latency: expected responses are queued at grant time and due one cycle later.
// Backpressure: none; the monitor checks every cycle for due, missing or unexpected responses.
module tb_im_arbiter;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int          DEP  = 1024;
  localparam int          SMAX = 4;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic        im_en;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [31:0] im_rdata;

  im_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .ld_err    (ld_err),
    .im_en     (im_en),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .im_rdata  (im_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Memory device: word-indexed synchronous RAM. When not reading it scrambles
  // im_rdata so ungated data paths show up as nonzero rdata.
  logic [31:0] dmem [DEP];
  always @(posedge clk) begin
    if (im_en && im_we) dmem[im_addr] <= im_wdata;
    if (im_en && !im_we) im_rdata <= dmem[im_addr];
    else                 im_rdata <= $urandom;
  end

  // Reference model state: contents keyed by byte address, loader wait count.
  logic [31:0] ref_mem [logic [31:0]];
  int          wait_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ld_gnt = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t if_q[$];
  exp_t ld_q[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit bad_a(input logic [31:0] a);
    longint unsigned la;
    la = a;
    return (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEP) || (a[1:0] != 2'b00);
  endfunction

  // One bus cycle: drive just after the rising edge, judge the combinational
  // grant at the falling edge, then queue what the response must be.
  task automatic do_cycle(input bit ir, input logic [31:0] ia, input bit lr,
                          input bit lwe, input logic [31:0] la, input logic [31:0] lwd);
    bit          ld_win, if_win, wr, b;
    logic [31:0] a;
    exp_t        ex;
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; ld_req = lr; ld_we = lwe; ld_addr = la; ld_wdata = lwd;
    @(negedge clk);
    ld_win = lr && (!ir || wait_cnt == SMAX);
    if_win = ir && !ld_win;
    chk1("if_gnt", if_gnt, if_win);
    chk1("ld_gnt", ld_gnt, ld_win);
    if (ld_gnt) n_ld_gnt++;
    if (if_win || ld_win) begin
      a  = ld_win ? la : ia;
      wr = ld_win && lwe;
      b  = bad_a(a);
      chk1("im_en", im_en, !b);
      if (!b) chk1("im_we", im_we, wr);
      if (!wr) begin
        ex.due = cyc + 1;
        ex.e   = b;
        ex.d   = b ? 32'h0 : ref_mem[a];
        if (ld_win) ld_q.push_back(ex);
        else        if_q.push_back(ex);
      end else if (!b) begin
        ref_mem[a] = lwd;
      end
    end else begin
      chk1("im_en_idle", im_en, 1'b0);
    end
    if (lr && !ld_win) wait_cnt = (wait_cnt < SMAX) ? wait_cnt + 1 : SMAX;
    else               wait_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  // Monitor: pop the response due this cycle, otherwise demand silence.
  task automatic resp(input bit p, input logic v, input logic [31:0] d, input logic e);
    exp_t ex;
    bit   due;
    due = 0;
    if (!p && if_q.size() > 0 && if_q[0].due == cyc) begin ex = if_q.pop_front(); due = 1; end
    if (p && ld_q.size() > 0 && ld_q[0].due == cyc) begin ex = ld_q.pop_front(); due = 1; end
    if (due) begin
      chk1(p ? "ld_rvalid" : "if_rvalid", v, 1'b1);
      chk32(p ? "ld_rdata" : "if_rdata", d, ex.d);
      chk1(p ? "ld_err" : "if_err", e, ex.e);
    end else begin
      chk1(p ? "ld_rvalid_idle" : "if_rvalid_idle", v, 1'b0);
      chk32(p ? "ld_rdata_idle" : "if_rdata_idle", d, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk1("reset_outputs_zero", |{if_gnt, if_rvalid, if_rdata, if_err, ld_gnt, ld_rvalid,
                                   ld_rdata, ld_err, im_en, im_we, im_addr, im_wdata}, 1'b0);
    end else begin
      resp(1'b0, if_rvalid, if_rdata, if_err);
      resp(1'b1, ld_rvalid, ld_rdata, ld_err);
    end
  end

  // Hold reset with live requests on the inputs, then release away from an edge.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    if_q.delete();
    ld_q.delete();
    wait_cnt = 0;
    if_req = 1; if_addr = BASE + 32'h4; ld_req = 1; ld_we = 0; ld_addr = BASE;
    repeat (n) @(negedge clk);
    if_req = 0; ld_req = 0; ld_we = 0;
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'(4 * $urandom_range(1, 4));
      1:       return BASE + 32'(4 * DEP) + 32'(4 * $urandom_range(0, 3));
      2:       return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      3:       return BASE + 32'(4 * $urandom_range(DEP - 4, DEP - 1));
      4:       return BASE + 32'(4 * $urandom_range(0, DEP - 1));
      default: return BASE + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    for (int i = 0; i < DEP; i++) begin
      v = $urandom;
      dmem[i] = v;
      ref_mem[BASE + 32'(4 * i)] = v;
    end
    dmem[1] = 32'h2408_0001;
    ref_mem[32'h3004] = 32'h2408_0001;
    if_req = 0; if_addr = 0; ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;

    // Power-on reset with requests active: everything must stay at 0.
    @(posedge clk);
    do_reset(3);

    // Single fetch of word 1.
    do_cycle(1, 32'h3004, 0, 0, 32'h0, 32'h0);
    idle(1);

    // Both ports requesting continuously: loader gets cycles 5 and 10 only.
    n_ld_gnt = 0;
    for (int i = 0; i < 10; i++) do_cycle(1, 32'h3000 + 32'(4 * i), 1, 0, 32'h3010, 32'h0);
    chk32("starve_ld_grants", 32'(n_ld_gnt), 32'd2);
    idle(1);

    // Loader write followed immediately by a fetch of the same word.
    do_cycle(0, 32'h0, 1, 1, 32'h3008, 32'hDEAD_BEEF);
    do_cycle(1, 32'h3008, 0, 0, 32'h0, 32'h0);
    idle(1);

    // Bad addresses: below window, past end, misaligned.
    do_cycle(1, 32'h2FFC, 0, 0, 32'h0, 32'h0);
    do_cycle(1, 32'h4000, 0, 0, 32'h0, 32'h0);
    do_cycle(1, 32'h3002, 0, 0, 32'h0, 32'h0);
    // Bad-address loader write is dropped; last word still readable.
    do_cycle(0, 32'h0, 1, 1, 32'h4000, 32'h1234_5678);
    do_cycle(1, 32'h3FFC, 0, 0, 32'h0, 32'h0);
    idle(1);

    // Back-to-back fetches.
    do_cycle(1, 32'h3000, 0, 0, 32'h0, 32'h0);
    do_cycle(1, 32'h3004, 0, 0, 32'h0, 32'h0);
    do_cycle(1, 32'h3008, 0, 0, 32'h0, 32'h0);
    idle(1);

    // Reset right after a granted fetch, with the loader half-starved.
    do_cycle(1, 32'h3000, 1, 0, 32'h3004, 32'h0);
    do_cycle(1, 32'h3004, 1, 0, 32'h3004, 32'h0);
    #1;
    do_reset(2);
    idle(2);
    // Counter restarts from zero after reset.
    n_ld_gnt = 0;
    for (int i = 0; i < 5; i++) do_cycle(1, 32'h3000, 1, 0, 32'h300C, 32'h0);
    chk32("post_reset_ld_grants", 32'(n_ld_gnt), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(0, 3) != 0), rnd_addr(),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
               rnd_addr(), $urandom);
    end
    idle(2);
    chk32("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk32("ld_queue_drained", 32'(ld_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net in case the stimulus process ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
